// File: rtl/alpha_trim_mean.sv
// Alpha-trimmed mean of one sorted window: keeps samples whose rank lies in
// [TRIM, DN-1-TRIM], sums them serially, then divides by KEEP with round-half-up.
module alpha_trim_mean #(
    parameter int DN          = 25,
    parameter int DW          = 8,
    parameter int DW_sequence = $clog2(DN),
    parameter int TRIM        = 4,
    parameter int SW          = DW + $clog2(DN)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sort_finish,
    input  logic [DW*DN-1:0]          data_in,
    input  logic [DW_sequence*DN-1:0] rank_in,
    output logic                      ready,
    output logic [DW-1:0]             mean_out,
    output logic                      mean_valid,
    output logic                      mean_err,
    output logic                      overrun
);

    localparam int KEEP = DN - 2 * TRIM;
    localparam int IW   = (DN > 1) ? $clog2(DN) : 1;
    localparam int CW   = $clog2(DN + 1);
    localparam int BW   = (SW > 1) ? $clog2(SW) : 1;

    localparam logic [DW_sequence-1:0] RANK_LO  = DW_sequence'(TRIM);
    localparam logic [DW_sequence-1:0] RANK_HI  = DW_sequence'(DN - 1 - TRIM);
    localparam logic [IW-1:0]          IDX_LAST = IW'(DN - 1);
    localparam logic [SW-1:0]          DIVISOR  = SW'(KEEP);
    localparam logic [SW-1:0]          SUM_INIT = SW'(KEEP >> 1);
    localparam logic [CW-1:0]          KEEP_CNT = CW'(KEEP);
    localparam logic [BW-1:0]          BIT_TOP  = BW'(SW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DIV
    } state_t;

    // Rank inside the retained band; out-of-range ranks (>= DN) fail the upper test.
    function automatic logic rank_kept(input logic [DW_sequence-1:0] rank);
        return (rank >= RANK_LO) && (rank <= RANK_HI);
    endfunction

    // One restoring-division step: returns {quotient bit, new remainder}.
    // The incoming remainder is always below DIVISOR, so the shift cannot lose its MSB.
    function automatic logic [SW:0] div_step(input logic [SW-1:0] rem, input logic din);
        logic [SW-1:0] trial;
        trial = {rem[SW-2:0], din};
        if (trial >= DIVISOR) begin
            return {1'b1, trial - DIVISOR};
        end
        return {1'b0, trial};
    endfunction

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [DW*DN-1:0]           r_data;
    logic [DW_sequence*DN-1:0]  r_rank;
    logic [IW-1:0]              r_idx;
    logic [SW-1:0]              r_sum;
    logic [CW-1:0]              r_kept;
    logic [SW-1:0]              r_rem;
    logic [SW-1:0]              r_quo;
    logic [BW-1:0]              r_bit;

    logic [DW-1:0]              w_sample;
    logic [DW_sequence-1:0]     w_rank;
    logic                       w_keep;
    logic [SW-1:0]              w_sum_nxt;
    logic [CW-1:0]              w_kept_nxt;
    logic [SW:0]                w_step;
    logic [SW-1:0]              w_quo_nxt;
    logic                       w_last_idx;
    logic                       w_last_bit;

    assign w_sample   = r_data[r_idx*DW +: DW];
    assign w_rank     = r_rank[r_idx*DW_sequence +: DW_sequence];
    assign w_keep     = rank_kept(w_rank);
    assign w_sum_nxt  = w_keep ? (r_sum + SW'(w_sample)) : r_sum;
    assign w_kept_nxt = w_keep ? (r_kept + CW'(1)) : r_kept;
    assign w_step     = div_step(r_rem, r_quo[SW-1]);
    assign w_quo_nxt  = {r_quo[SW-2:0], w_step[SW]};
    assign w_last_idx = (r_idx == IDX_LAST);
    assign w_last_bit = (r_bit == '0);

    assign ready = (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (sort_finish) w_state_nxt = S_ACC;
            S_ACC:  if (w_last_idx)  w_state_nxt = S_DIV;
            S_DIV:  if (w_last_bit)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_rank     <= '0;
            r_idx      <= '0;
            r_sum      <= '0;
            r_kept     <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_bit      <= '0;
            mean_out   <= '0;
            mean_valid <= 1'b0;
            mean_err   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            mean_valid <= 1'b0;
            if (sort_finish && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (sort_finish) begin
                        r_data <= data_in;
                        r_rank <= rank_in;
                        r_idx  <= '0;
                        r_sum  <= SUM_INIT;
                        r_kept <= '0;
                    end
                end
                S_ACC: begin
                    r_sum  <= w_sum_nxt;
                    r_kept <= w_kept_nxt;
                    r_idx  <= r_idx + IW'(1);
                    if (w_last_idx) begin
                        r_quo <= w_sum_nxt;
                        r_rem <= '0;
                        r_bit <= BIT_TOP;
                    end
                end
                S_DIV: begin
                    // Dividend bits shift out of r_quo's MSB as quotient bits enter its LSB.
                    r_rem <= w_step[SW-1:0];
                    r_quo <= w_quo_nxt;
                    r_bit <= r_bit - BW'(1);
                    if (w_last_bit) begin
                        mean_out   <= w_quo_nxt[DW-1:0];
                        mean_valid <= 1'b1;
                        mean_err   <= (r_kept != KEEP_CNT);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
